// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame
// Description : UART serial transmitter. Sends one start bit (0), eight data
//               bits LSB-first, an optional even-parity bit and one stop bit
//               (1). The line idles high. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 10,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       tx_done
);

    // Bit-period timer sized to hold 0..CLKS_PER_BIT-1
    localparam int                   c_timer_w   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_timer_w-1:0] c_timer_max = c_timer_w'(CLKS_PER_BIT - 1);
    localparam logic [c_timer_w-1:0] c_timer_one = c_timer_w'(1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    logic [2:0]           r_state;
    logic [c_timer_w-1:0] r_timer;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_data;
    logic                 r_parity;
    logic                 r_serial;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_bit_end;

    // Last clock of the current bit period
    assign w_bit_end = (r_timer == c_timer_max);

    // Frame sequencer: each state's line value is set on the edge that enters
    // it, so serial_out is a plain flop with no decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
            r_parity  <= 1'b0;
            r_serial  <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_timer <= w_bit_end ? '0 : (r_timer + c_timer_one);
            case (r_state)
                c_st_idle: begin
                    r_timer   <= '0;
                    r_bit_idx <= '0;
                    r_serial  <= 1'b1;
                    r_busy    <= 1'b0;
                    if (tx_start) begin
                        r_data   <= tx_data;
                        r_parity <= ^tx_data;
                        r_state  <= c_st_start;
                        r_serial <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                c_st_start: begin
                    if (w_bit_end) begin
                        r_state   <= c_st_data;
                        r_bit_idx <= '0;
                        r_serial  <= r_data[0];
                    end
                end
                c_st_data: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
                            if (PARITY_EN) begin
                                r_state  <= c_st_parity;
                                r_serial <= r_parity;
                            end else begin
                                r_state  <= c_st_stop;
                                r_serial <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_serial  <= r_data[r_bit_idx + 3'd1];
                        end
                    end
                end
                c_st_parity: begin
                    if (w_bit_end) begin
                        r_state  <= c_st_stop;
                        r_serial <= 1'b1;
                    end
                end
                c_st_stop: begin
                    if (w_bit_end) begin
                        r_state  <= c_st_idle;
                        r_serial <= 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= c_st_idle;
                    r_timer  <= '0;
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign serial_out = r_serial;
    assign tx_busy    = r_busy;
    assign tx_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_frame
// Description : Self-checking bench for uart_tx_frame. One instance without
//               parity, one with parity. A per-instance line monitor decodes
//               each frame and compares it against a queue of expected bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

    localparam int c_n       = 10;
    localparam int c_timeout = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       ser0, busy0, done0;
    logic       ser1, busy1, done1;

    int n_total = 0;
    int n_bad   = 0;

    // Expected frames: {parity, data}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    bit         mon_en0 = 1'b1;
    bit         mon_en1 = 1'b1;
    int         done_cnt0 = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(c_n), .PARITY_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .tx_start(start0), .tx_data(data0),
        .serial_out(ser0), .tx_busy(busy0), .tx_done(done0)
    );

    uart_tx_frame #(.CLKS_PER_BIT(c_n), .PARITY_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_start(start1), .tx_data(data1),
        .serial_out(ser1), .tx_busy(busy1), .tx_done(done1)
    );

    always @(posedge clk) if (done0 === 1'b1) done_cnt0 <= done_cnt0 + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ser_of(input bit s);  return s ? ser1  : ser0;  endfunction
    function automatic logic busy_of(input bit s); return s ? busy1 : busy0; endfunction
    function automatic logic done_of(input bit s); return s ? done1 : done0; endfunction
    function automatic bit   mon_on(input bit s);  return s ? mon_en1 : mon_en0; endfunction

    // Line monitor: detects a start bit, checks every cycle of every bit
    task automatic monitor(input bit s);
        logic       prev;
        logic [8:0] e;
        logic [7:0] got;
        logic       ob, eb;
        bit         ctl_bad, aborted, pend_low;
        int         nbits;
        prev     = 1'b1;
        pend_low = 1'b0;
        nbits    = s ? 11 : 10;
        forever begin
            @(posedge clk); #1;
            if (rst || !mon_on(s)) begin
                prev     = 1'b1;
                pend_low = 1'b0;
            end else begin
                if (pend_low) begin
                    chk($sformatf("d%0d_done_one_shot", s), done_of(s), 0);
                    pend_low = 1'b0;
                end
                if (ser_of(s) === 1'b0 && prev === 1'b1) begin
                    e = '0;
                    if (s) begin
                        if (q1.size() == 0) chk("d1_unexpected_frame", 1, 0);
                        else e = q1.pop_front();
                    end else begin
                        if (q0.size() == 0) chk("d0_unexpected_frame", 1, 0);
                        else e = q0.pop_front();
                    end
                    got     = '0;
                    ctl_bad = 1'b0;
                    aborted = 1'b0;
                    for (int b = 0; b < nbits && !aborted; b++) begin
                        if (b == 0)                eb = 1'b0;
                        else if (b <= 8)           eb = e[b-1];
                        else if (b == 9 && s)      eb = e[8];
                        else                       eb = 1'b1;
                        ob = eb;
                        for (int c = 0; c < c_n; c++) begin
                            if (b != 0 || c != 0) begin @(posedge clk); #1; end
                            if (rst || !mon_on(s)) begin aborted = 1'b1; break; end
                            if (ser_of(s) !== eb) ob = ser_of(s);
                            if (c == c_n/2 && b >= 1 && b <= 8) got[b-1] = ser_of(s);
                            if (busy_of(s) !== 1'b1 || done_of(s) !== 1'b0) ctl_bad = 1'b1;
                        end
                        if (!aborted) chk($sformatf("d%0d_bit%0d", s, b), ob, eb);
                    end
                    if (!aborted) begin
                        chk($sformatf("d%0d_byte", s), got, e[7:0]);
                        chk($sformatf("d%0d_busy_in_frame", s), ctl_bad, 0);
                        @(posedge clk); #1;
                        chk($sformatf("d%0d_done_pulse", s), done_of(s), 1);
                        chk($sformatf("d%0d_busy_after", s), busy_of(s), 0);
                        chk($sformatf("d%0d_idle_gap", s), ser_of(s), 1);
                        pend_low = 1'b1;
                    end
                    prev = 1'b1;
                end else begin
                    prev = ser_of(s);
                end
            end
        end
    endtask

    initial monitor(1'b0);
    initial monitor(1'b1);

    task automatic send(input bit s, input logic [7:0] d, input logic p, input bit push);
        int t;
        t = 0;
        while (busy_of(s) !== 1'b0 && t < c_timeout) begin @(posedge clk); #1; t++; end
        if (t >= c_timeout) chk("wait_idle_timeout", 1, 0);
        if (s) begin
            start1 = 1'b1; data1 = d;
            if (push) q1.push_back({p, d});
        end else begin
            start0 = 1'b1; data0 = d;
            if (push) q0.push_back({p, d});
        end
        @(posedge clk); #1;
        chk("accept_busy", busy_of(s), 1);
        chk("accept_start_bit", ser_of(s), 0);
        if (s) start1 = 1'b0; else start0 = 1'b0;
    endtask

    task automatic wait_done(input bit s);
        int t;
        t = 0;
        while (done_of(s) !== 1'b1 && t < c_timeout) begin @(posedge clk); #1; t++; end
        if (t >= c_timeout) chk("wait_done_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        // Reset asserted mid-clock takes effect at once
        #23;
        rst = 1'b1;
        #1;
        chk("rst_ser0", ser0, 1);
        chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_ser1", ser1, 1);
        chk("rst_busy1", busy1, 0);
        chk("rst_done1", done1, 0);
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;

        // Plain frame
        send(1'b0, 8'hA5, 1'b0, 1'b1);
        wait_done(1'b0);

        // Parity frames
        send(1'b1, 8'h07, 1'b1, 1'b1);
        wait_done(1'b1);
        send(1'b1, 8'h03, 1'b0, 1'b1);
        wait_done(1'b1);

        // Start request while busy is ignored
        cnt = done_cnt0;
        send(1'b0, 8'hFF, 1'b0, 1'b1);
        repeat (39) @(posedge clk);
        #1;
        start0 = 1'b1; data0 = 8'h3C;
        @(posedge clk); #1;
        start0 = 1'b0;
        chk("busy_ignore_start", busy0, 1);
        wait_done(1'b0);
        repeat (150) @(posedge clk);
        #1;
        chk("ignored_single_done", done_cnt0 - cnt, 1);
        chk("ignored_queue_empty", q0.size(), 0);
        chk("ignored_line_idle", ser0, 1);

        // Held start: back-to-back frames with one idle cycle
        start0 = 1'b1; data0 = 8'h55; q0.push_back({1'b0, 8'h55});
        @(posedge clk); #1;
        chk("b2b_accept1", busy0, 1);
        data0 = 8'hAA; q0.push_back({1'b0, 8'hAA});
        wait_done(1'b0);
        @(posedge clk); #1;
        chk("b2b_start2", ser0, 0);
        chk("b2b_busy2", busy0, 1);
        start0 = 1'b0;
        wait_done(1'b0);
        repeat (5) @(posedge clk);
        #1;

        // Reset in the middle of data bit 3
        mon_en0 = 1'b0;
        send(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (44) @(posedge clk);
        #3;
        chk("abort_mid_bit3", ser0, 0);
        cnt = done_cnt0;
        rst = 1'b1;
        #1;
        chk("abort_ser", ser0, 1);
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        #20;
        rst = 1'b0;
        @(posedge clk); #1;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt0 - cnt, 0);
        chk("abort_line_idle", ser0, 1);
        mon_en0 = 1'b1;
        @(posedge clk); #1;
        send(1'b0, 8'h81, 1'b0, 1'b1);
        wait_done(1'b0);
        repeat (5) @(posedge clk);
        #1;

        chk("final_q0_empty", q0.size(), 0);
        chk("final_q1_empty", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
